mr_row_seq: RTL and testbench
=============================

# mr_row_seq

Row sequencer upstream of the matrix-by-real multiply stage (`mult_MR`). It latches a full 5×5 signed 8-bit matrix and a scalar, then issues one 40-bit row per cycle to the multiply stage. It collects the returned rows into a 200-bit result matrix and ORs the per-row overflow into one sticky flag. It exposes a start/busy/done handshake to the coprocessor control FSM.

## Interface
- `MAT_DIM`, 5: rows per matrix; also elements per row.
- `ELEM_W`, 8: signed element width.
- `MULT_LAT`, 1: multiply-stage latency in cycles, from `row_out` applied to `row_in` valid. Must be ≥ 1.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request an operation; sampled only in IDLE.
- `mat_in`  in  200: source matrix.
  - Row r is at `[199-40r -: 40]`.
  - Element 0 of a row is at its `[39:32]`.
- `n_in`  in  8: signed scalar.
- `row_out`  out  40: row to the multiply stage's `m_1`.
- `scalar_out`  out  8: scalar to the multiply stage's `n`.
- `row_in`  in  40: the multiply stage's `m_out`.
- `ovf_in`  in  1: the multiply stage's `ovf`.
- `mat_out`  out  200: result matrix, same layout as `mat_in`.
- `ovf_out`  out  1: sticky OR of `ovf_in` over all 5 captured rows.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse when the result is complete.

## Operation
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE, `start`=1:
  - latch `mat_in` and `n_in`
  - clear `ovf_out`, `mat_out` and the issue counter
  - go to ISSUE.
- ISSUE:
  - drive `row_out` = latched row[cnt] and `scalar_out` = latched n
  - push `{valid=1, idx=cnt}` into a MULT_LAT-deep tag pipe
  - increment cnt; after cnt=4 go to DRAIN.
- Capture, any state: when the tag pipe output is valid, write `row_in` into `mat_out` row idx and OR `ovf_in` into `ovf_out`.
- DRAIN: wait until the tag pipe is empty, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Outputs outside ISSUE:
  - `row_out` and `scalar_out` = 0.
  - The tag pipe shifts every cycle with valid=0.
- `start` while busy is ignored, not queued.
- `mat_out` and `ovf_out` hold after DONE until the next accepted `start`.
- No arithmetic in this block. Saturation and overflow detection belong to the multiply stage; results pass through bit-exact.
- Reset (sync, any state, including mid-operation):
  - state IDLE; cnt, tag pipe, latched operands, `mat_out`, `ovf_out`, `row_out`, `scalar_out`, `busy` and `done` all 0
  - in-flight multiply results are dropped, no `done`
  - `rst` has priority over `start`.

## Timing
- `start` sampled at edge 0; ISSUE occupies cycles 1–5, row i is on `row_out` in cycle 1+i.
- Row i is captured at the end of cycle 1+i+MULT_LAT.
- `done` is high in cycle 6+MULT_LAT (cycle 7 for MULT_LAT=1); `busy` is high in cycles 1 through 6+MULT_LAT.
- The earliest next accepted `start` is in the cycle after `done` (IDLE).
- Throughput: one matrix per 7+MULT_LAT cycles.
- `mat_out` is only guaranteed complete while `done`=1 and afterwards; intermediate rows are visible during operation.
- `ovf_out` is monotone within an operation.

## Structure
- Shared package `coproc_pkg`:
  - `MAT_DIM`, `ELEM_W`, `ROW_W`=40, `MAT_W`=200
  - the state enum {IDLE, ISSUE, DRAIN, DONE}
  - row-slice helper function.
- One sub-module, `tag_pipe`: a MULT_LAT-deep shift register of {valid, 3-bit idx} with a synchronous clear on `rst`.
- `mult_MR` stays outside. The parent datapath wires `row_out`, `scalar_out`, `row_in` and `ovf_in` to it and drives both from the same `clk`/`rst`.

## Test plan
Bench uses a behavioural `mult_MR` model: registered, MULT_LAT=1, 8-bit wrap, ovf on signed overflow.
1. Basic multiply: all rows [2,3,4,5,0], n=3 → every `mat_out` row = [6,9,12,15,0]; `ovf_out`=0; `done` in cycle 7 only.
2. Negative scalar: row 2 = [2,-3,4,-5,0], other rows zero, n=-3 → row 2 = 0xFA_09_F4_0F_00, other rows 0, `ovf_out`=0.
3. Overflow in one row: row 4 = [10,11,12,13,0], other rows [1,1,1,1,1], n=11 → row 4 = 0x6E_79_84_8F_00, `ovf_out`=1; other rows = 0x0B each.
4. Start while busy: `start` held high through the whole operation → exactly one `done`. A second `start` in the cycle after `done` is accepted and clears `ovf_out` on acceptance.
5. Reset mid-operation: `rst` in cycle 3 → next cycle all outputs 0, `busy`=0, no `done` ever. A fresh `start` then completes normally.
6. MULT_LAT=3 instance: `done` in cycle 9; row ordering in `mat_out` is correct.

Source files
------------

// File: rtl/mr_row_seq_pkg.sv
// Shared coprocessor definitions: matrix geometry, sequencer states and row slicing.
package coproc_pkg;

    localparam int MAT_DIM = 5;
    localparam int ELEM_W  = 8;
    localparam int ROW_W   = MAT_DIM * ELEM_W;
    localparam int MAT_W   = MAT_DIM * ROW_W;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Row 0 occupies the most significant bits of the packed matrix.
    function automatic logic [ROW_W-1:0] row_slice(input logic [MAT_W-1:0] mat,
                                                   input logic [IDX_W-1:0] r);
        return mat[MAT_W-1-ROW_W*int'(r) -: ROW_W];
    endfunction

endpackage

// File: rtl/mr_row_seq_if.sv
// Bundle between the row sequencer (slave) and its parent datapath/control (master).
interface mr_row_seq_if;
    import coproc_pkg::*;

    logic              start;
    logic [MAT_W-1:0]  mat_in;
    logic [ELEM_W-1:0] n_in;
    logic [ROW_W-1:0]  row_out;
    logic [ELEM_W-1:0] scalar_out;
    logic [ROW_W-1:0]  row_in;
    logic              ovf_in;
    logic [MAT_W-1:0]  mat_out;
    logic              ovf_out;
    logic              busy;
    logic              done;

    modport master (
        output start, mat_in, n_in, row_in, ovf_in,
        input  row_out, scalar_out, mat_out, ovf_out, busy, done
    );

    modport slave (
        input  start, mat_in, n_in, row_in, ovf_in,
        output row_out, scalar_out, mat_out, ovf_out, busy, done
    );

endinterface

// File: rtl/mr_row_seq_tag_pipe.sv
// Row-index tags travelling alongside the multiply stage, DEPTH cycles deep.
module tag_pipe
    import coproc_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld_i,
    input  logic [IDX_W-1:0] push_idx_i,
    output logic             out_vld_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             pending_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= push_vld_i;
            idx_q[0] <= push_idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // Pending excludes the output stage: that tag is consumed on this edge.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending_o = pending_o | vld_q[i];
        end
    end

    assign out_vld_o = vld_q[DEPTH-1];
    assign out_idx_o = idx_q[DEPTH-1];

endmodule

// File: rtl/mr_row_seq.sv
// Row sequencer feeding mult_MR one row per cycle and reassembling the result matrix.
//  state | meaning
//  IDLE  | waiting for start
//  ISSUE | one latched row per cycle to the multiply stage
//  DRAIN | waiting for the last rows to return
//  DONE  | result complete, done pulse
module mr_row_seq
    import coproc_pkg::*;
#(
    parameter int MULT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    mr_row_seq_if.slave bus
);

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [MAT_W-1:0]  mat_lat_q;
    logic [ROW_W-1:0]  row_out_q;
    logic [ELEM_W-1:0] scalar_out_q;
    logic [MAT_W-1:0]  mat_out_q;
    logic              ovf_out_q;
    logic              busy_q;
    logic              done_q;

    logic              cap_vld;
    logic [IDX_W-1:0]  cap_idx;
    logic              pending;

    tag_pipe #(.DEPTH(MULT_LAT)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (state_q == ISSUE),
        .push_idx_i (cnt_q),
        .out_vld_o  (cap_vld),
        .out_idx_o  (cap_idx),
        .pending_o  (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mat_lat_q    <= '0;
            row_out_q    <= '0;
            scalar_out_q <= '0;
            mat_out_q    <= '0;
            ovf_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cap_vld) begin
                for (int r = 0; r < MAT_DIM; r++) begin
                    if (cap_idx == IDX_W'(r)) begin
                        mat_out_q[MAT_W-1-ROW_W*r -: ROW_W] <= bus.row_in;
                    end
                end
                ovf_out_q <= ovf_out_q | bus.ovf_in;
            end
            // row_out/scalar_out are loaded one edge ahead so they are registered in ISSUE.
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mat_lat_q    <= bus.mat_in;
                        mat_out_q    <= '0;
                        ovf_out_q    <= 1'b0;
                        cnt_q        <= '0;
                        row_out_q    <= row_slice(bus.mat_in, '0);
                        scalar_out_q <= bus.n_in;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q == IDX_W'(MAT_DIM - 1)) begin
                        row_out_q    <= '0;
                        scalar_out_q <= '0;
                        state_q      <= DRAIN;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        row_out_q <= row_slice(mat_lat_q, cnt_q + 1'b1);
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.row_out    = row_out_q;
    assign bus.scalar_out = scalar_out_q;
    assign bus.mat_out    = mat_out_q;
    assign bus.ovf_out    = ovf_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_mr_row_seq.sv
// Self-checking bench for mr_row_seq with behavioural multiply stages (latency 1 and 3).
module tb_mr_row_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mr_row_seq_if ifa ();
    mr_row_seq_if ifb ();

    mr_row_seq #(.MULT_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mr_row_seq #(.MULT_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Elementwise signed product, wrapped to 8 bits; bit 40 flags any out-of-range product.
    function automatic logic [40:0] mult_row(input logic [39:0] r, input logic [7:0] n);
        logic [40:0] res;
        int p;
        res = '0;
        for (int e = 0; e < 5; e++) begin
            p = int'($signed(r[39-8*e -: 8])) * int'($signed(n));
            res[39-8*e -: 8] = p[7:0];
            if (p > 127 || p < -128) res[40] = 1'b1;
        end
        return res;
    endfunction

    function automatic logic [39:0] mk_row(input int a, input int b, input int c,
                                           input int d, input int e);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e)};
    endfunction

    logic [40:0] pa, pb0, pb1, pb2;
    always @(posedge clk) begin
        if (rst) pa <= '0;
        else     pa <= mult_row(ifa.row_out, ifa.scalar_out);
    end
    always @(posedge clk) begin
        if (rst) begin
            pb0 <= '0; pb1 <= '0; pb2 <= '0;
        end else begin
            pb0 <= mult_row(ifb.row_out, ifb.scalar_out);
            pb1 <= pb0;
            pb2 <= pb1;
        end
    end
    assign ifa.row_in = pa[39:0];
    assign ifa.ovf_in = pa[40];
    assign ifb.row_in = pb2[39:0];
    assign ifb.ovf_in = pb2[40];

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation in the current cycle (edge 0 is the next posedge) and checks
    // every cycle up to and including the idle cycle after done.
    task automatic run_op(input bit sel, input logic [199:0] m, input logic [7:0] n,
                          input bit hold);
        int L;
        logic [199:0] em, om;
        logic eo, ob, od, oo;
        logic [40:0] rr;
        logic [39:0] orow;
        logic [7:0] osc;
        L  = sel ? 3 : 1;
        em = '0;
        eo = 1'b0;
        for (int r = 0; r < 5; r++) begin
            rr = mult_row(m[199-40*r -: 40], n);
            em[199-40*r -: 40] = rr[39:0];
            eo = eo | rr[40];
        end
        if (sel) begin ifb.start = 1'b1; ifb.mat_in = m; ifb.n_in = n; end
        else     begin ifa.start = 1'b1; ifa.mat_in = m; ifa.n_in = n; end
        for (int c = 1; c <= 7 + L; c++) begin
            tick();
            if (c == 1) begin
                if (!hold) begin ifa.start = 1'b0; ifb.start = 1'b0; end
                ifa.mat_in = ~m; ifa.n_in = ~n;
                ifb.mat_in = ~m; ifb.n_in = ~n;
            end
            ob   = sel ? ifb.busy       : ifa.busy;
            od   = sel ? ifb.done       : ifa.done;
            oo   = sel ? ifb.ovf_out    : ifa.ovf_out;
            om   = sel ? ifb.mat_out    : ifa.mat_out;
            orow = sel ? ifb.row_out    : ifa.row_out;
            osc  = sel ? ifb.scalar_out : ifa.scalar_out;
            chk("busy", 200'(ob), 200'(c <= 6 + L));
            chk("done", 200'(od), 200'(c == 6 + L));
            chk("row_out", 200'(orow), 200'(c <= 5 ? m[199-40*(c-1) -: 40] : 40'd0));
            chk("scalar_out", 200'(osc), 200'(c <= 5 ? n : 8'd0));
            if (c == 1) begin
                chk("ovf_clear", 200'(oo), 200'(1'b0));
                chk("mat_clear", om, 200'd0);
            end
            if (c >= 6 + L) begin
                chk("mat_out", om, em);
                chk("ovf_out", 200'(oo), 200'(eo));
            end
        end
    endtask

    logic [199:0] m1, m2, m3, m6, mr;
    logic [7:0]   nr;

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifa.mat_in = '0; ifa.n_in = '0;
        ifb.start = 1'b0; ifb.mat_in = '0; ifb.n_in = '0;
        tick();
        tick();
        chk("rst_busy_a", 200'(ifa.busy), 200'd0);
        chk("rst_done_a", 200'(ifa.done), 200'd0);
        chk("rst_row_a", 200'(ifa.row_out), 200'd0);
        chk("rst_mat_a", ifa.mat_out, 200'd0);
        chk("rst_ovf_a", 200'(ifa.ovf_out), 200'd0);
        chk("rst_busy_b", 200'(ifb.busy), 200'd0);
        rst = 1'b0;
        tick();

        m1 = {5{mk_row(2, 3, 4, 5, 0)}};
        run_op(1'b0, m1, 8'd3, 1'b0);
        chk("t1_row0", 200'(ifa.mat_out[199:160]), 200'(40'h06090C0F00));
        tick();

        m2 = {mk_row(0, 0, 0, 0, 0), mk_row(0, 0, 0, 0, 0), mk_row(2, -3, 4, -5, 0),
              mk_row(0, 0, 0, 0, 0), mk_row(0, 0, 0, 0, 0)};
        run_op(1'b0, m2, 8'hFD, 1'b0);
        chk("t2_row2", 200'(ifa.mat_out[119:80]), 200'(40'hFA09F40F00));
        tick();

        m3 = {{4{mk_row(1, 1, 1, 1, 1)}}, mk_row(10, 11, 12, 13, 0)};
        run_op(1'b0, m3, 8'd11, 1'b0);
        chk("t3_row4", 200'(ifa.mat_out[39:0]), 200'(40'h6E79848F00));
        chk("t3_row0", 200'(ifa.mat_out[199:160]), 200'(40'h0B0B0B0B0B));
        chk("t3_ovf", 200'(ifa.ovf_out), 200'd1);
        tick();

        // start held throughout, then a back-to-back second op that must clear ovf_out
        run_op(1'b0, m3, 8'd11, 1'b1);
        run_op(1'b0, m1, 8'd3, 1'b0);
        tick();

        ifa.start = 1'b1; ifa.mat_in = m1; ifa.n_in = 8'd3;
        tick();
        ifa.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 200'(ifa.busy), 200'd0);
        chk("rst_mid_row", 200'(ifa.row_out), 200'd0);
        chk("rst_mid_scalar", 200'(ifa.scalar_out), 200'd0);
        chk("rst_mid_mat", ifa.mat_out, 200'd0);
        chk("rst_mid_ovf", 200'(ifa.ovf_out), 200'd0);
        for (int k = 0; k < 12; k++) begin
            chk("rst_mid_done", 200'(ifa.done), 200'd0);
            chk("rst_mid_mat_hold", ifa.mat_out, 200'd0);
            tick();
        end
        run_op(1'b0, m2, 8'hFD, 1'b0);
        tick();

        m6 = {mk_row(1, 2, 3, 4, 5), mk_row(6, 7, 8, 9, 10), mk_row(11, 12, 13, 14, 15),
              mk_row(16, 17, 18, 19, 20), mk_row(21, 22, 23, 24, 25)};
        run_op(1'b1, m6, 8'd2, 1'b0);
        chk("t6_row3", 200'(ifb.mat_out[79:40]), 200'(40'h2022242628));
        chk("t6_row4", 200'(ifb.mat_out[39:0]), 200'(40'h2A2C2E3032));
        tick();

        for (int k = 0; k < 24; k++) begin
            for (int w = 0; w < 25; w++) mr[8*w +: 8] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) nr = 8'($urandom_range(0, 8)) - 8'd4;
            else                           nr = 8'($urandom);
            run_op(1'($urandom_range(0, 1)), mr, nr, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
